// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI initiator.
//   spi_state_t : transfer sequencing states
//   SCK_IDLE    : serial clock level between transfers (mode 0)
//   MOSI_IDLE   : serial data level between transfers
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      DONE
   } spi_state_t;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_half_period_cnt.sv
// spi_half_period_cnt: phase timer for the SPI initiator.
// Loaded with (H-1) at the start of each phase, counts down to zero;
// expire is high during the last clock of the phase, so a phase that is
// loaded with load_val lasts load_val+1 clocks.
//   clock    : system clock
//   reset    : asynchronous, active-high
//   load     : restart the phase timer with load_val
//   load_val : half-period minus one
//   expire   : last clock of the current phase
module spi_half_period_cnt (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       expire
);

   logic [7:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != 8'd0) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   assign expire = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_master.sv
// spi_master: single-lane SPI initiator, mode 0, MSB first.
// One command in through a valid/ready port, received bits returned on a
// response port held until taken.
//   clock, reset              : system clock, async active-high reset
//   cmd_valid/cmd_ready       : command handshake (ready only when idle)
//   cmd_data, cmd_len         : right-justified tx bits and bit count
//   cmd_ss, cmd_div           : one-hot select, half-period H = cmd_div+1
//   rsp_valid/rsp_ready       : response handshake
//   rsp_data                  : received bits, right-justified
//   sck, ss, mosi, miso       : SPI bus (ss active-low)
//
// state | meaning
// IDLE  | waiting for a command, bus idle
// SETUP | ss asserted, first bit on mosi, sck low for H clocks
// HIGH  | sck high for H clocks, miso sampled on the last one
// LOW   | sck low for H clocks; after the last bit this is the ss hold time
// DONE  | bus idle, response held until rsp_ready
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int SS_W   = 8,
   parameter int LEN_W  = $clog2(DATA_W) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [SS_W-1:0]   cmd_ss,
   input  logic [7:0]        cmd_div,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              sck,
   output logic [SS_W-1:0]   ss,
   output logic              mosi,
   input  logic              miso
);

   spi_state_t state_q, state_nx;

   logic [DATA_W-1:0] tx_q, tx_nx;
   logic [DATA_W-1:0] rx_q, rx_nx;
   logic [LEN_W-1:0]  bit_q, bit_nx;
   logic [7:0]        div_q, div_nx;
   logic              sck_q, sck_nx;
   logic [SS_W-1:0]   ss_q, ss_nx;
   logic              mosi_q, mosi_nx;
   logic [DATA_W-1:0] rsp_q, rsp_nx;

   logic              cnt_load;
   logic [7:0]        cnt_val;
   logic              expire;

   logic [LEN_W-1:0]  len_c;
   logic [DATA_W-1:0] tx_align;

   spi_half_period_cnt u_half_period_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .expire   (expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sck_q   <= SCK_IDLE;
         ss_q    <= '1;
         mosi_q  <= MOSI_IDLE;
         rsp_q   <= '0;
      end else begin
         state_q <= state_nx;
         tx_q    <= tx_nx;
         rx_q    <= rx_nx;
         bit_q   <= bit_nx;
         div_q   <= div_nx;
         sck_q   <= sck_nx;
         ss_q    <= ss_nx;
         mosi_q  <= mosi_nx;
         rsp_q   <= rsp_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      tx_nx    = tx_q;
      rx_nx    = rx_q;
      bit_nx   = bit_q;
      div_nx   = div_q;
      sck_nx   = sck_q;
      ss_nx    = ss_q;
      mosi_nx  = mosi_q;
      rsp_nx   = rsp_q;
      cnt_load = 1'b0;
      cnt_val  = div_q;
      len_c    = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
      // Left-align so the first bit to send always sits in the MSB.
      tx_align = cmd_data << (LEN_W'(DATA_W) - len_c);

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               div_nx = cmd_div;
               bit_nx = len_c;
               rx_nx  = '0;
               tx_nx  = tx_align;
               if (len_c == '0) begin
                  state_nx = DONE;
                  rsp_nx   = '0;
               end else begin
                  state_nx = SETUP;
                  ss_nx    = ~cmd_ss;
                  mosi_nx  = tx_align[DATA_W-1];
                  cnt_load = 1'b1;
                  cnt_val  = cmd_div;
               end
            end
         end
         SETUP: begin
            if (expire) begin
               state_nx = HIGH;
               sck_nx   = 1'b1;
               cnt_load = 1'b1;
            end
         end
         HIGH: begin
            if (expire) begin
               state_nx = LOW;
               sck_nx   = 1'b0;
               cnt_load = 1'b1;
               rx_nx    = {rx_q[DATA_W-2:0], miso};
               bit_nx   = bit_q - LEN_W'(1);
               if (bit_q == LEN_W'(1)) begin
                  mosi_nx = MOSI_IDLE;
               end else begin
                  tx_nx   = tx_q << 1;
                  mosi_nx = tx_q[DATA_W-2];
               end
            end
         end
         LOW: begin
            if (expire) begin
               if (bit_q != '0) begin
                  state_nx = HIGH;
                  sck_nx   = 1'b1;
                  cnt_load = 1'b1;
               end else begin
                  state_nx = DONE;
                  ss_nx    = '1;
                  rsp_nx   = rx_q;
               end
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = rsp_q;
   assign sck       = sck_q;
   assign ss        = ss_q;
   assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data;
   logic [4:0]  cmd_len;
   logic [7:0]  cmd_ss;
   logic [7:0]  cmd_div;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        sck;
   logic [7:0]  ss;
   logic        mosi;
   logic        miso;

   int checks = 0;
   int errors = 0;

   spi_master dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .cmd_ss    (cmd_ss),
      .cmd_div   (cmd_div),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .sck       (sck),
      .ss        (ss),
      .mosi      (mosi),
      .miso      (miso)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   // mode 0: loopback slave (miso = mosi captured one sck rise earlier)
   // mode 1: miso tied high
   // mode 2: bit-reversal slave (receives a byte, returns it reversed)
   task automatic xfer(input logic [15:0] data, input logic [4:0] len, input logic [7:0] sel,
                       input logic [7:0] div, input int mode, input int hold);
      int          lc, h, n, rises, mask;
      bit          tim_ok, mosi_ok, ss_ok, act, hold_ok;
      logic [15:0] exp_rx;
      logic        prev_sck, lb;
      logic [7:0]  rx8, rv;
      lc   = (len > 5'd16) ? 16 : int'(len);
      h    = int'(div) + 1;
      mask = (1 << lc) - 1;
      case (mode)
         0:       exp_rx = 16'((int'(data) & mask) >> 1);
         1:       exp_rx = 16'(mask);
         default: exp_rx = {8'h00, rev8(data[15:8])};
      endcase
      miso = 1'b0;
      chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_data  = data;
      cmd_len   = len;
      cmd_ss    = sel;
      cmd_div   = div;
      @(posedge clock);
      @(negedge clock);
      n = 1;
      cmd_valid = (hold > 0);
      cmd_data  = 16'($urandom);
      cmd_len   = 5'($urandom);
      cmd_ss    = 8'($urandom);
      cmd_div   = 8'($urandom);
      if (lc > 0) begin
         chk("first_ss", {24'd0, ss}, {24'd0, ~sel});
         chk("first_mosi", {31'd0, mosi}, {31'd0, data[lc-1]});
      end
      prev_sck = 1'b0; rises = 0; lb = 1'b0; rx8 = 8'h00;
      tim_ok = 1; mosi_ok = 1; ss_ok = 1; act = 0;
      while (rsp_valid !== 1'b1 && n < 400) begin
         if (ss !== 8'hFF || sck !== 1'b0) act = 1;
         if (lc > 0 && ss !== ~sel) ss_ok = 0;
         if (sck === 1'b1 && prev_sck === 1'b0) begin
            if (n != 1 + h + 2*h*rises) tim_ok = 0;
            if (rises < lc) begin
               if (mosi !== data[lc-1-rises]) mosi_ok = 0;
            end else mosi_ok = 0;
            case (mode)
               0: begin miso = lb; lb = mosi; end
               1: miso = 1'b1;
               default: begin
                  if (rises < 8) begin
                     rx8  = {rx8[6:0], mosi};
                     miso = 1'b0;
                  end else begin
                     rv   = rev8(rx8);
                     miso = rv[15-rises];
                  end
               end
            endcase
            rises++;
         end
         if (sck === 1'b0 && prev_sck === 1'b1) begin
            if (n != 1 + 2*h + 2*h*(rises-1)) tim_ok = 0;
         end
         prev_sck = sck;
         @(negedge clock);
         n++;
      end
      chk("rsp_cycle", n, (lc == 0) ? 1 : 1 + h + 2*h*lc);
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_rx});
      chk("done_ss", {24'd0, ss}, 32'hFF);
      chk("done_sck_mosi", {30'd0, sck, mosi}, 32'd1);
      chk("sck_rises", rises, lc);
      if (lc == 0) chk("len0_no_activity", {31'd0, act}, 32'd0);
      else begin
         chk("phase_timing", {31'd0, tim_ok}, 32'd1);
         chk("mosi_bits", {31'd0, mosi_ok}, 32'd1);
         chk("ss_held", {31'd0, ss_ok}, 32'd1);
      end
      if (hold > 0) begin
         hold_ok = 1;
         for (int i = 0; i < hold; i++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_rx) hold_ok = 0;
            @(negedge clock);
         end
         chk("hold_stable", {31'd0, hold_ok}, 32'd1);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      chk("ready_after_rsp", {30'd0, cmd_ready, rsp_valid}, 32'd2);
   endtask

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_len   = '0;
      cmd_ss    = '0;
      cmd_div   = '0;
      rsp_ready = 1'b0;
      miso      = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("reset_state", {6'd0, sck, ss, mosi, cmd_ready, rsp_valid, rsp_data},
          {6'd0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0000});
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // loopback, div=0, len=8, 8'hA5
      xfer(16'h00A5, 5'd8, 8'h01, 8'd0, 0, 0);
      // bit-reversal slave, len=16
      xfer(16'hB100, 5'd16, 8'h01, 8'd0, 2, 0);
      // div=3, len=4, miso tied high
      xfer(16'h0005, 5'd4, 8'h04, 8'd3, 1, 0);
      // len=0
      xfer(16'hFFFF, 5'd0, 8'h10, 8'd2, 1, 0);
      // len=20 clamps to 16
      xfer(16'h3C5A, 5'd20, 8'h80, 8'd1, 0, 0);
      // response held 10 cycles with cmd_valid high, then back-to-back command
      xfer(16'h1234, 5'd6, 8'h02, 8'd1, 0, 10);
      xfer(16'h0ACE, 5'd12, 8'h20, 8'd0, 1, 0);

      for (int t = 0; t < 14; t++) begin
         xfer(16'($urandom), 5'($urandom_range(0, 20)), 8'(1 << $urandom_range(0, 7)),
              8'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // reset during HIGH with ss=8'hFE
      cmd_valid = 1'b1;
      cmd_data  = 16'h00F0;
      cmd_len   = 5'd8;
      cmd_ss    = 8'h01;
      cmd_div   = 8'd2;
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && sck !== 1'b1; i++) @(negedge clock);
      chk("pre_reset_high", {23'd0, sck, ss}, {23'd0, 1'b1, 8'hFE});
      #2 reset = 1'b1;
      #1;
      chk("async_reset_bus", {20'd0, sck, ss, mosi, rsp_valid, cmd_ready},
          {20'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1});
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
